// File: rtl/sha256_scan_ctrl.sv
// Nonce-scan sequencer for one sha256_transform: issues a nonce every LOOP cycles and tags each returning hash.
// golden_valid lands HASH_LATENCY+1 cycles after issue; no backpressure, results are consumed the cycle they arrive.
module sha256_scan_ctrl #(
   parameter int LOOP         = 1,
   parameter int HASH_LATENCY = 65
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         abort,
   input  logic [255:0] midstate,
   input  logic [95:0]  data_tail,
   input  logic [31:0]  nonce_start,
   input  logic [31:0]  nonce_end,
   input  logic [31:0]  target,
   input  logic [255:0] tx_hash,
   output logic         feedback,
   output logic [5:0]   cnt,
   output logic [255:0] rx_state,
   output logic [511:0] rx_input,
   output logic         busy,
   output logic         done,
   output logic         golden_valid,
   output logic [31:0]  golden_nonce
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [5:0] CNT_LAST = 6'(LOOP - 1);

   state_t state;
   state_t state_nxt;

   logic [HASH_LATENCY-1:0] pipe;
   logic [HASH_LATENCY-1:0] pipe_nxt;
   logic [HASH_LATENCY:0]   pipe_shift;
   logic [31:0]             check_nonce;
   logic [31:0]             check_nonce_nxt;
   logic [31:0]             end_q;
   logic [31:0]             target_q;
   logic [31:0]             issue_nonce;

   logic         active;
   logic         issue;
   logic         check;
   logic         start_ok;
   logic         golden_hit;
   logic         advance;
   logic         hash_low_unused;

   logic         feedback_nxt;
   logic [5:0]   cnt_nxt;
   logic [255:0] rx_state_nxt;
   logic [511:0] rx_input_nxt;
   logic         busy_nxt;
   logic         done_nxt;
   logic [31:0]  golden_nonce_nxt;

   // The nonce being offered to the transform lives directly in word 3 of the message block.
   assign issue_nonce     = rx_input[127:96];
   assign active          = (state == RUN) || (state == DRAIN);
   assign issue           = (state == RUN) && (cnt == 6'd0);
   assign check           = active && pipe[HASH_LATENCY-1];
   assign start_ok        = (state == IDLE) && start && !abort;
   assign golden_hit      = check && !abort && (tx_hash[255:224] <= target_q);
   assign advance         = issue && (state_nxt == RUN);
   assign pipe_shift      = {pipe, issue};
   assign hash_low_unused = ^tx_hash[223:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (issue && (issue_nonce == end_q)) state_nxt = DRAIN;
            DRAIN:   if (pipe == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      cnt_nxt = 6'd0;
      if (active && ((state_nxt == RUN) || (state_nxt == DRAIN))) begin
         cnt_nxt = (cnt == CNT_LAST) ? 6'd0 : cnt + 6'd1;
      end
      feedback_nxt = (cnt_nxt != 6'd0);
      busy_nxt     = (state_nxt == RUN) || (state_nxt == DRAIN);
      done_nxt     = (state_nxt == DONE);

      // Abort flushes the in-flight tags so late hashes can never raise golden_valid.
      pipe_nxt = '0;
      if (active && !abort) begin
         pipe_nxt = pipe_shift[HASH_LATENCY-1:0];
      end

      rx_state_nxt = rx_state;
      rx_input_nxt = rx_input;
      if (start_ok) begin
         rx_state_nxt = midstate;
         rx_input_nxt = {32'd640, 320'd0, 32'h8000_0000, nonce_start, data_tail};
      end else if (advance) begin
         rx_input_nxt[127:96] = issue_nonce + 32'd1;
      end

      check_nonce_nxt = check_nonce;
      if (start_ok) begin
         check_nonce_nxt = nonce_start;
      end else if (check && !abort) begin
         check_nonce_nxt = check_nonce + 32'd1;
      end

      golden_nonce_nxt = golden_hit ? check_nonce : golden_nonce;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         feedback     <= 1'b0;
         cnt          <= 6'd0;
         rx_state     <= '0;
         rx_input     <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         golden_valid <= 1'b0;
         golden_nonce <= 32'd0;
         pipe         <= '0;
         check_nonce  <= 32'd0;
         end_q        <= 32'd0;
         target_q     <= 32'd0;
      end else begin
         feedback     <= feedback_nxt;
         cnt          <= cnt_nxt;
         rx_state     <= rx_state_nxt;
         rx_input     <= rx_input_nxt;
         busy         <= busy_nxt;
         done         <= done_nxt;
         golden_valid <= golden_hit;
         golden_nonce <= golden_nonce_nxt;
         pipe         <= pipe_nxt;
         check_nonce  <= check_nonce_nxt;
         if (start_ok) begin
            end_q    <= nonce_end;
            target_q <= target;
         end
      end
   end

endmodule

// File: tb/tb_sha256_scan_ctrl.sv
// Drives two controllers (LOOP=1 and LOOP=4) from shared stimulus, with a nonce-keyed transform model and
// a cycle-indexed reference model of the scan schedule.
module tb_sha256_scan_ctrl;

   localparam int LP0 = 1;
   localparam int HL0 = 65;
   localparam int LP1 = 4;
   localparam int HL1 = 17;

   logic         clk;
   logic         reset;
   logic         start;
   logic         abort;
   logic [255:0] midstate;
   logic [95:0]  data_tail;
   logic [31:0]  nonce_start;
   logic [31:0]  nonce_end;
   logic [31:0]  target;
   logic [255:0] tx_hash      [2];
   logic         feedback     [2];
   logic [5:0]   cnt          [2];
   logic [255:0] rx_state     [2];
   logic [511:0] rx_input     [2];
   logic         busy         [2];
   logic         done         [2];
   logic         golden_valid [2];
   logic [31:0]  golden_nonce [2];

   sha256_scan_ctrl #(.LOOP(LP0), .HASH_LATENCY(HL0)) u_dut0 (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .midstate(midstate), .data_tail(data_tail), .nonce_start(nonce_start),
      .nonce_end(nonce_end), .target(target), .tx_hash(tx_hash[0]),
      .feedback(feedback[0]), .cnt(cnt[0]), .rx_state(rx_state[0]), .rx_input(rx_input[0]),
      .busy(busy[0]), .done(done[0]), .golden_valid(golden_valid[0]), .golden_nonce(golden_nonce[0])
   );

   sha256_scan_ctrl #(.LOOP(LP1), .HASH_LATENCY(HL1)) u_dut1 (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .midstate(midstate), .data_tail(data_tail), .nonce_start(nonce_start),
      .nonce_end(nonce_end), .target(target), .tx_hash(tx_hash[1]),
      .feedback(feedback[1]), .cnt(cnt[1]), .rx_state(rx_state[1]), .rx_input(rx_input[1]),
      .busy(busy[1]), .done(done[1]), .golden_valid(golden_valid[1]), .golden_nonce(golden_nonce[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk;
   int n_pass;
   int edge_cnt;

   // Hash top word as a pure function of the nonce; the rest of the hash is noise.
   int          hmode;
   logic [31:0] hseed;

   function automatic logic [31:0] htop(input logic [31:0] n);
      if (hmode == 0) return (n == 32'd2) ? 32'd0 : 32'hFFFF_FFFF;
      return (n * 32'h9E37_79B1) ^ hseed;
   endfunction

   function automatic logic [223:0] rnd224();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic int lp_of(input int d);
      return (d == 0) ? LP0 : LP1;
   endfunction

   function automatic int hl_of(input int d);
      return (d == 0) ? HL0 : HL1;
   endfunction

   task automatic chk(input string name, input int d, input logic [511:0] act, input logic [511:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
   endtask

   // Transform model: remembers the nonce seen on each feedback=0 edge and answers HASH_LATENCY edges later.
   bit          hist_v [2][128];
   logic [31:0] hist_n [2][128];

   always @(negedge clk) begin : transform_model
      int e;
      int p;
      e = edge_cnt + 1;
      for (int d = 0; d < 2; d++) begin
         hist_v[d][e % 128] = (feedback[d] === 1'b0);
         hist_n[d][e % 128] = rx_input[d][127:96];
         p = e - hl_of(d);
         if (p >= 0 && hist_v[d][p % 128]) tx_hash[d] = {htop(hist_n[d][p % 128]), rnd224()};
         else tx_hash[d] = {$urandom, rnd224()};
      end
   end

   // Reference model: a scan is a start edge S, N nonces, and everything else is a function of j = edges since S.
   bit           m_on    [2];
   bit           m_fresh [2];
   int           m_j     [2];
   int           m_d     [2];
   int           m_n     [2];
   logic [31:0]  m_ns    [2];
   logic [31:0]  m_tgt   [2];
   logic [31:0]  m_gl    [2];
   logic [255:0] m_mid   [2];
   logic [95:0]  m_tail  [2];

   function automatic bit exp_gv(input int d, output logic [31:0] nonce);
      int k;
      nonce = 32'd0;
      if (!m_on[d] || m_j[d] < 1 + hl_of(d)) return 1'b0;
      if ((m_j[d] - 1 - hl_of(d)) % lp_of(d) != 0) return 1'b0;
      k = (m_j[d] - 1 - hl_of(d)) / lp_of(d);
      if (k >= m_n[d]) return 1'b0;
      nonce = m_ns[d] + 32'(k);
      return htop(nonce) <= m_tgt[d];
   endfunction

   task automatic model_update(input int d);
      logic [31:0] g;
      if (reset) begin
         m_on[d]    = 1'b0;
         m_gl[d]    = 32'd0;
         m_fresh[d] = 1'b1;
         return;
      end
      if (m_on[d]) begin
         if (abort) m_on[d] = 1'b0;
         else begin
            m_j[d]++;
            if (m_j[d] > m_d[d]) m_on[d] = 1'b0;
         end
      end else if (start && !abort) begin
         m_on[d]    = 1'b1;
         m_fresh[d] = 1'b0;
         m_j[d]     = 0;
         m_ns[d]    = nonce_start;
         m_tgt[d]   = target;
         m_mid[d]   = midstate;
         m_tail[d]  = data_tail;
         m_n[d]     = int'(nonce_end - nonce_start + 32'd1);
         m_d[d]     = (m_n[d] - 1) * lp_of(d) + hl_of(d) + 2;
      end
      if (exp_gv(d, g)) m_gl[d] = g;
   endtask

   task automatic compare(input int d);
      bit          run;
      bit          gv;
      int          ec;
      int          k;
      logic [31:0] g;
      run = m_on[d] && (m_j[d] < m_d[d]);
      ec  = run ? (m_j[d] % lp_of(d)) : 0;
      gv  = exp_gv(d, g);
      chk("busy", d, busy[d], run);
      chk("done", d, done[d], m_on[d] && (m_j[d] == m_d[d]));
      chk("cnt", d, cnt[d], 6'(ec));
      chk("feedback", d, feedback[d], ec != 0);
      chk("golden_valid", d, golden_valid[d], gv);
      chk("golden_nonce", d, golden_nonce[d], m_gl[d]);
      if (m_fresh[d]) begin
         chk("rx_state_reset", d, rx_state[d], 256'd0);
         chk("rx_input_reset", d, rx_input[d], 512'd0);
      end
      if (run) chk("rx_state", d, rx_state[d], m_mid[d]);
      k = m_j[d] / lp_of(d);
      if (run && (m_j[d] % lp_of(d) == 0) && k < m_n[d])
         chk("rx_input", d, rx_input[d],
             {32'd640, 320'd0, 32'h8000_0000, m_ns[d] + 32'(k), m_tail[d]});
   endtask

   logic [31:0] gq0 [$];
   logic [31:0] gq1 [$];
   logic [31:0] w3q [$];
   int          gv_cnt    [2];
   int          dn_cnt    [2];
   int          done_edge [2];

   always @(posedge clk) begin
      edge_cnt++;
      model_update(0);
      model_update(1);
      #2;
      compare(0);
      compare(1);
      if (golden_valid[0] === 1'b1) gq0.push_back(golden_nonce[0]);
      if (golden_valid[1] === 1'b1) gq1.push_back(golden_nonce[1]);
      if (busy[1] === 1'b1 && cnt[1] == 6'd0 && w3q.size() < 3) w3q.push_back(rx_input[1][127:96]);
      for (int d = 0; d < 2; d++) begin
         if (golden_valid[d] === 1'b1) gv_cnt[d]++;
         if (done[d] === 1'b1) begin
            dn_cnt[d]++;
            done_edge[d] = edge_cnt;
         end
      end
   end

   task automatic clear_obs();
      gq0.delete();
      gq1.delete();
      w3q.delete();
      for (int d = 0; d < 2; d++) begin
         gv_cnt[d]    = 0;
         dn_cnt[d]    = 0;
         done_edge[d] = -1;
      end
   endtask

   task automatic do_start(input logic [31:0] ns, input logic [31:0] ne, input logic [31:0] tg, output int s);
      @(negedge clk);
      midstate    = {rnd224(), $urandom};
      data_tail   = {$urandom, $urandom, $urandom};
      nonce_start = ns;
      nonce_end   = ne;
      target      = tg;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      s     = edge_cnt;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy[0] || busy[1] || done[0] || done[1]) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) begin
         n_chk++;
         $display("FAIL wait_idle: still busy after %0d cycles, required idle", n);
      end
      @(negedge clk);
   endtask

   task automatic chk_q(input string name, input int d, input logic [31:0] q [$], input logic [31:0] e [$]);
      chk({name, "_count"}, d, q.size(), e.size());
      for (int i = 0; i < e.size() && i < q.size(); i++) chk(name, d, q[i], e[i]);
   endtask

   initial begin
      int s;
      int s2;
      int exp_cnt;
      logic [31:0] ns;
      logic [31:0] tg;
      int len;
      n_chk = 0; n_pass = 0; edge_cnt = 0;
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      midstate = '0; data_tail = '0; nonce_start = '0; nonce_end = '0; target = '0;
      hmode = 0; hseed = 32'd0;
      clear_obs();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Only nonce 2 meets target 0.
      clear_obs();
      hmode = 0;
      do_start(32'd0, 32'd3, 32'd0, s);
      wait_idle();
      chk_q("t1_golden", 0, gq0, '{32'd2});
      chk_q("t1_golden", 1, gq1, '{32'd2});
      chk("t1_done_time", 0, done_edge[0] - s, 70);
      chk("t1_done_time", 1, done_edge[1] - s, 31);

      clear_obs();
      hmode = 1;
      hseed = $urandom;
      do_start(32'd10, 32'd12, $urandom, s);
      wait_idle();
      chk_q("t2_word3", 1, w3q, '{32'd10, 32'd11, 32'd12});

      clear_obs();
      do_start(32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFF, s);
      wait_idle();
      chk_q("t3_wrap", 0, gq0, '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1});
      chk_q("t3_wrap", 1, gq1, '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1});

      for (int i = 0; i < 6; i++) begin
         clear_obs();
         hseed = $urandom;
         ns    = (i % 2 == 1) ? $urandom : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         len   = $urandom_range(1, 20);
         tg    = $urandom;
         exp_cnt = 0;
         for (int k = 0; k < len; k++) if (htop(ns + 32'(k)) <= tg) exp_cnt++;
         do_start(ns, ns + 32'(len - 1), tg, s);
         wait_idle();
         chk("rand_golden_count", 0, gq0.size(), exp_cnt);
         chk("rand_golden_count", 1, gq1.size(), exp_cnt);
         chk("rand_done_count", 0, dn_cnt[0], 1);
      end

      clear_obs();
      do_start(32'd0, 32'd99, 32'hFFFF_FFFF, s);
      repeat (19) @(negedge clk);
      abort = 1'b1;
      clear_obs();
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", 0, busy[0], 1'b0);
      chk("abort_busy", 1, busy[1], 1'b0);
      repeat (200) @(negedge clk);
      chk("abort_golden", 0, gv_cnt[0], 0);
      chk("abort_golden", 1, gv_cnt[1], 0);
      chk("abort_done", 0, dn_cnt[0], 0);
      chk("abort_done", 1, dn_cnt[1], 0);

      // A second start mid-scan must leave the single-nonce range untouched.
      clear_obs();
      do_start(32'd5, 32'd5, 32'hFFFF_FFFF, s);
      repeat (10) @(negedge clk);
      do_start(32'd200, 32'd300, 32'hFFFF_FFFF, s2);
      wait_idle();
      chk_q("t5_single", 0, gq0, '{32'd5});
      chk_q("t5_single", 1, gq1, '{32'd5});
      chk("t5_done", 0, dn_cnt[0], 1);
      chk("t5_done", 1, dn_cnt[1], 1);

      clear_obs();
      do_start(32'd0, 32'd3, 32'hFFFF_FFFF, s);
      repeat (30) @(negedge clk);
      reset = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_feedback", d, feedback[d], 1'b0);
         chk("rst_cnt", d, cnt[d], 6'd0);
         chk("rst_rx_state", d, rx_state[d], 256'd0);
         chk("rst_rx_input", d, rx_input[d], 512'd0);
         chk("rst_busy", d, busy[d], 1'b0);
         chk("rst_done", d, done[d], 1'b0);
         chk("rst_golden_valid", d, golden_valid[d], 1'b0);
         chk("rst_golden_nonce", d, golden_nonce[d], 32'd0);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      clear_obs();
      do_start(32'd7, 32'd9, 32'hFFFF_FFFF, s);
      wait_idle();
      chk_q("t6_after_reset", 0, gq0, '{32'd7, 32'd8, 32'd9});
      chk_q("t6_after_reset", 1, gq1, '{32'd7, 32'd8, 32'd9});
      chk("t6_done_time", 0, done_edge[0] - s, 69);
      chk("t6_done_time", 1, done_edge[1] - s, 27);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sha256_scan_ctrl.md
# sha256_scan_ctrl

Nonce-scan controller that sequences one `sha256_transform` instance through a range of 32-bit nonces for a fixed midstate and header tail. It drives `feedback`, `cnt`, `rx_state` and `rx_input`, and tracks which nonce each `tx_hash` belongs to. It flags every hash whose top word is at or below a target. It sits between the work-distribution logic and the hashing datapath.

## Interface
- `LOOP`, 1 — unroll factor of the driven transform; one nonce is issued every `LOOP` cycles; allowed values 1, 2, 4, 8, 16, 32, 64.
- `HASH_LATENCY`, 65 — cycles from a nonce being issued (`feedback`=0 sample edge) to its `tx_hash` being valid; integrator sets it per `LOOP`.
- `clk` input 1 — single clock; all logic on rising edge.
- `reset` input 1 — asynchronous, active-high; clears all state.
- `start` input 1 — pulse in IDLE; loads the work registers.
- `abort` input 1 — returns to IDLE from any state.
- `midstate` input 256 — first-chunk state, latched on `start`.
- `data_tail` input 96 — header words 16..18, latched on `start`.
- `nonce_start` input 32 — first nonce, inclusive.
- `nonce_end` input 32 — last nonce, inclusive.
- `target` input 32 — golden threshold on `tx_hash[255:224]`.
- `tx_hash` input 256 — result from the transform.
- `feedback` output 1 — to the transform.
- `cnt` output 6 — to the transform.
- `rx_state` output 256 — latched midstate.
- `rx_input` output 512 — message block.
- `busy` output 1 — high in RUN or DRAIN.
- `done` output 1 — one-cycle pulse when a scan completes.
- `golden_valid` output 1 — one-cycle pulse per qualifying hash.
- `golden_nonce` output 32 — nonce of the last qualifying hash.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on `start`. On that edge the block:
  - latches `midstate`, `data_tail`, `nonce_start`, `nonce_end`, `target`;
  - sets `issue_nonce`=`nonce_start`, `check_nonce`=`nonce_start`, `cnt`=0.
- `start` outside IDLE is ignored.
- RUN:
  - `cnt` counts 0..LOOP-1 and wraps.
  - `feedback` = (`cnt` != 0).
  - Each cycle with `cnt`==0 issues `issue_nonce` and shifts a 1 into a `HASH_LATENCY`-deep valid shift register. Other cycles shift in 0.
  - When the issued nonce equals `nonce_end`, the block goes to DRAIN. Otherwise `issue_nonce` increments mod 2^32, so wrap from FFFFFFFF to 00000000 is legal.
- DRAIN:
  - `cnt` and the shifter keep running; only 0s are shifted in.
  - The block goes to DONE when the shifter is all zero and no result is pending.
- DONE: `done`=1 for one cycle, then IDLE.
- Result check, in RUN and DRAIN: when the shifter's output bit is 1, `tx_hash` belongs to `check_nonce`.
  - If `tx_hash[255:224]` <= `target` (unsigned), the next cycle has `golden_valid`=1 and `golden_nonce`=`check_nonce`.
  - `check_nonce` increments mod 2^32 after every checked result.
- `rx_input` layout (word n = bits 32n+31:32n):
  - words 0..2 = `data_tail`;
  - word 3 = `issue_nonce`;
  - word 4 = 32'h80000000;
  - words 5..14 = 0;
  - word 15 = 32'd640.
- `abort`: goes to IDLE next edge, clears the shifter, `busy`=0. No `done`. No further `golden_valid`, including for hashes in flight.
- `nonce_end`==`nonce_start` issues exactly one nonce. `nonce_end`=`nonce_start`-1 scans all 2^32 nonces.

## Timing
- Reset values:
  - state IDLE; `feedback`=0, `cnt`=0;
  - `rx_state`=0, `rx_input`=0;
  - `busy`=0, `done`=0, `golden_valid`=0, `golden_nonce`=0.
- `feedback`, `cnt`, `rx_input`, `rx_state`, `busy`, `done`, `golden_*` are all registered.
- `busy` rises the cycle after `start` and falls the same cycle `done` pulses.
- First issue: the first cycle after `start`, with `cnt`=0.
- Throughput is one nonce per `LOOP` cycles. With `LOOP`=1, consecutive golden hashes give consecutive `golden_valid` pulses.
- `golden_valid` comes 1 cycle after the matching `tx_hash` is valid, i.e. `HASH_LATENCY`+1 cycles after issue.
- `done` comes the cycle after the last result is checked. With `LOOP`=1 and N nonces, `done` is at start+N+`HASH_LATENCY`+1.
- `reset` mid-scan: outputs return to reset values immediately, asynchronously. No pulses after reset is released.

## Test plan
- `LOOP`=1, range 0..3, transform model returning top word 0 for nonce 2 and FFFFFFFF otherwise, `target`=0 -> exactly one `golden_valid`, `golden_nonce`=2, `done` at start+70.
- `LOOP`=4, range 10..12 -> `cnt` sequence 0,1,2,3 repeating; `feedback` low only at `cnt`=0; `rx_input` word 3 = 10, 11, 12 at successive `cnt`=0 cycles.
- Range FFFFFFFE..00000001 with all hashes golden (`target`=FFFFFFFF) -> 4 pulses with nonces FFFFFFFE, FFFFFFFF, 0, 1.
- `abort` 20 cycles into a 100-nonce scan -> `busy`=0 next cycle; no `done`; zero `golden_valid` over the following 200 cycles.
- `start` while `busy`, and `start` with `nonce_end`==`nonce_start` -> the busy-time `start` is ignored and the current range is unaffected; the equal-bound scan issues exactly one nonce and gives one `done`.
- `reset` asserted mid-DRAIN -> all outputs at reset values within the same cycle; a subsequent `start` scans correctly.
